// File: rtl/riscv_mem_port_arbiter.sv
// Shares one single-port 32-bit memory between instruction fetch and the load/store unit,
// one outstanding transaction at a time, with LSU byte-lane decode and load extension.
module riscv_mem_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [2:0]  ls_funct3,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  logic [1:0]    state;
  logic [CW-1:0] starve_cnt;
  logic          owner_ls;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic          ls_win;
  logic          unused_bits;

  function automatic logic ls_fault(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic illegal;
    logic misaligned;
    illegal    = we ? (f3 >= 3'b011) : (f3 == 3'b011 || f3[2:1] == 2'b11);
    misaligned = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
    return illegal | misaligned;
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] rd);
    logic [31:0]        shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    shifted = rd >> {a, 3'b000};
    byte_s  = shifted[7:0];
    half_s  = a[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  return 32'(byte_s);
      3'b100:  return {24'd0, byte_s};
      3'b001:  return 32'(half_s);
      3'b101:  return {16'd0, half_s};
      default: return rd;
    endcase
  endfunction

  // IF only wins a contested cycle once the LSU has starved it STARVE_MAX times in a row
  assign ls_win  = ls_req && !(if_req && starve_cnt == SMAX);
  assign ls_gnt  = (state == S_IDLE) && !rst && ls_win;
  assign if_gnt  = (state == S_IDLE) && !rst && if_req && !ls_win;
  assign mem_req = (state == S_BUS);

  assign unused_bits = &{1'b0, if_addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      starve_cnt <= '0;
      owner_ls   <= 1'b0;
      f3_q       <= 3'd0;
      off_q      <= 2'd0;
      if_rvalid  <= 1'b0;
      if_rdata   <= 32'd0;
      ls_rvalid  <= 1'b0;
      ls_rdata   <= 32'd0;
      ls_err     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_be     <= 4'd0;
      mem_wdata  <= 32'd0;
    end else begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      ls_err    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ls_gnt) begin
            if (if_req) begin
              if (starve_cnt != SMAX) starve_cnt <= starve_cnt + 1'b1;
            end else begin
              starve_cnt <= '0;
            end
            owner_ls <= 1'b1;
            f3_q     <= ls_funct3;
            off_q    <= ls_addr[1:0];
            if (ls_fault(ls_we, ls_funct3, ls_addr[1:0])) begin
              state     <= S_ERR;
              ls_rvalid <= 1'b1;
              ls_err    <= 1'b1;
              ls_rdata  <= 32'd0;
            end else begin
              state     <= S_BUS;
              mem_we    <= ls_we;
              mem_addr  <= {ls_addr[31:2], 2'b00};
              mem_be    <= lane_be(ls_funct3, ls_addr[1:0]);
              mem_wdata <= lane_data(ls_funct3, ls_wdata);
            end
          end else if (if_gnt) begin
            starve_cnt <= '0;
            owner_ls   <= 1'b0;
            state      <= S_BUS;
            mem_we     <= 1'b0;
            mem_addr   <= {if_addr[31:2], 2'b00};
            mem_be     <= 4'hF;
            mem_wdata  <= 32'd0;
          end
        end
        S_BUS: begin
          if (mem_gnt) state <= S_RESP;
        end
        S_RESP: begin
          if (mem_rvalid) begin
            state <= S_IDLE;
            if (owner_ls) begin
              ls_rvalid <= 1'b1;
              ls_rdata  <= mem_we ? 32'd0 : load_extend(f3_q, off_q, mem_rdata);
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mem_port_arbiter.sv
// Scoreboard bench for riscv_mem_port_arbiter: directed IF/LS transactions against a
// behavioural memory, with grant order, memory bus fields and responses checked from queues.
module tb_riscv_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0, ls_we = 1'b0;
  logic [31:0] ls_addr = 32'd0;
  logic [2:0]  ls_funct3 = 3'd0;
  logic [31:0] ls_wdata = 32'd0;
  logic        ls_gnt, ls_rvalid, ls_err;
  logic [31:0] ls_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  riscv_mem_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_funct3(ls_funct3), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_t;

  typedef struct {
    logic        is_ls;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } resp_t;

  mem_t        exp_mem[$];
  resp_t       exp_resp[$];
  logic        exp_gnt[$];
  logic [31:0] mem_img[logic [31:0]];

  int   total = 0, bad = 0, cyc = 0, resp_seen = 0, gnt_cyc = 0, gnt_delay = 0, stray_req = 0;
  logic hold_rv = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever @(posedge clk) cyc++;

  // Response and grant monitor
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (if_rvalid || ls_rvalid) begin
        if (exp_resp.size() == 0) begin
          chk("unexpected_rvalid", {if_rvalid, ls_rvalid}, 2'b00);
        end else begin
          e = exp_resp.pop_front();
          chk("resp_owner", {if_rvalid, ls_rvalid}, e.is_ls ? 2'b01 : 2'b10);
          chk("resp_data", e.is_ls ? ls_rdata : if_rdata, e.rdata);
          if (e.is_ls) chk("resp_err", ls_err, e.err);
          if (e.lat != 0) chk("resp_latency", cyc - gnt_cyc, e.lat);
        end
        resp_seen++;
      end
      if (if_gnt || ls_gnt) begin
        if (exp_gnt.size() == 0) chk("unexpected_gnt", {if_gnt, ls_gnt}, 2'b00);
        else chk("gnt_owner", {if_gnt, ls_gnt}, exp_gnt.pop_front() ? 2'b01 : 2'b10);
        gnt_cyc = cyc;
      end
    end
  end

  // Memory model: grants after gnt_delay waiting cycles, answers the cycle after the grant
  initial begin
    int          waited = 0;
    int          stray_done = 0;
    logic [31:0] a = 32'd0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (stray_req != stray_done) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        stray_done++;
      end
      if (mem_gnt) begin
        mem_gnt = 1'b0;
        if (!hold_rv) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_img.exists(a) ? mem_img[a] : ~a;
        end
      end else if (mem_req) begin
        if (exp_mem.size() == 0) begin
          chk("unexpected_mem_req", mem_req, 1'b0);
        end else begin
          chk("mem_addr", mem_addr, exp_mem[0].addr);
          chk("mem_we", mem_we, exp_mem[0].we);
          chk("mem_be", mem_be, exp_mem[0].be);
          if (exp_mem[0].we) chk("mem_wdata", mem_wdata, exp_mem[0].wdata);
        end
        if (waited >= gnt_delay) begin
          mem_gnt = 1'b1;
          a       = mem_addr;
          waited  = 0;
          if (exp_mem.size() != 0) exp_mem.delete(0);
        end else begin
          waited++;
        end
      end
    end
  end

  task automatic wait_gnt(input logic is_ls);
    logic got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      got = is_ls ? ls_gnt : if_gnt;
    end
    chk(is_ls ? "ls_gnt_seen" : "if_gnt_seen", got, 1'b1);
  endtask

  task automatic wait_done(input int target);
    for (int n = 0; n < 200 && resp_seen < target; n++) @(negedge clk);
    chk("resp_count", resp_seen, target);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_ctrl"}, {if_gnt, if_rvalid, ls_gnt, ls_rvalid, ls_err, mem_req, mem_we, mem_be}, 0);
    chk({name, "_rdata"}, {if_rdata, ls_rdata}, 0);
    chk({name, "_mem"}, {mem_addr, mem_wdata}, 0);
  endtask

  task automatic if_op(input logic [31:0] addr, input logic [31:0] rd, input int lat);
    int target;
    exp_gnt.push_back(1'b0);
    exp_mem.push_back('{1'b0, {addr[31:2], 2'b00}, 4'hF, 32'd0});
    exp_resp.push_back('{1'b0, rd, 1'b0, lat});
    target = resp_seen + 1;
    @(posedge clk); #1;
    if_req  = 1'b1;
    if_addr = addr;
    wait_gnt(1'b0);
    @(posedge clk); #1 if_req = 1'b0;
    wait_done(target);
  endtask

  task automatic ls_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be, input logic [31:0] mwd,
                       input logic err, input logic [31:0] rd, input int lat);
    int target;
    exp_gnt.push_back(1'b1);
    if (!err) exp_mem.push_back('{we, {addr[31:2], 2'b00}, be, mwd});
    exp_resp.push_back('{1'b1, rd, err, lat});
    target = resp_seen + 1;
    @(posedge clk); #1;
    ls_req = 1'b1; ls_we = we; ls_funct3 = f3; ls_addr = addr; ls_wdata = wd;
    wait_gnt(1'b1);
    @(posedge clk); #1 ls_req = 1'b0;
    wait_done(target);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int target;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Plain fetches, low address bits ignored
    mem_img[32'h100] = 32'h0000_0013;
    mem_img[32'h104] = 32'h0000_0093;
    if_op(32'h100, 32'h0000_0013, 3);
    if_op(32'h107, 32'h0000_0093, 3);

    // Loads with lane selection and extension
    mem_img[32'h200] = 32'h8011_2233;
    ls_op(1'b0, 3'b000, 32'h203, 32'd0, 4'b1000, 32'd0, 1'b0, 32'hFFFF_FF80, 3);
    ls_op(1'b0, 3'b100, 32'h203, 32'd0, 4'b1000, 32'd0, 1'b0, 32'h0000_0080, 3);
    ls_op(1'b0, 3'b101, 32'h202, 32'd0, 4'b1100, 32'd0, 1'b0, 32'h0000_8011, 3);
    ls_op(1'b0, 3'b001, 32'h202, 32'd0, 4'b1100, 32'd0, 1'b0, 32'hFFFF_8011, 3);
    ls_op(1'b0, 3'b001, 32'h200, 32'd0, 4'b0011, 32'd0, 1'b0, 32'h0000_2233, 3);
    ls_op(1'b0, 3'b000, 32'h201, 32'd0, 4'b0010, 32'd0, 1'b0, 32'h0000_0022, 3);
    ls_op(1'b0, 3'b010, 32'h200, 32'd0, 4'b1111, 32'd0, 1'b0, 32'h8011_2233, 3);

    // Stores
    ls_op(1'b1, 3'b001, 32'h102, 32'hDEAD_BEEF, 4'b1100, 32'hBEEF_BEEF, 1'b0, 32'd0, 3);
    ls_op(1'b1, 3'b000, 32'h101, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5, 1'b0, 32'd0, 3);
    ls_op(1'b1, 3'b010, 32'h104, 32'h1234_5678, 4'b1111, 32'h1234_5678, 1'b0, 32'd0, 3);

    // Misaligned and illegal accesses never reach the memory
    ls_op(1'b0, 3'b010, 32'h101, 32'd0, 4'd0, 32'd0, 1'b1, 32'd0, 1);
    ls_op(1'b1, 3'b011, 32'h100, 32'h55, 4'd0, 32'd0, 1'b1, 32'd0, 1);
    ls_op(1'b0, 3'b001, 32'h201, 32'd0, 4'd0, 32'd0, 1'b1, 32'd0, 1);
    ls_op(1'b0, 3'b110, 32'h200, 32'd0, 4'd0, 32'd0, 1'b1, 32'd0, 1);
    ls_op(1'b1, 3'b010, 32'h102, 32'h77, 4'd0, 32'd0, 1'b1, 32'd0, 1);

    // Reset while waiting in RESP; the late memory response must be discarded
    hold_rv = 1'b1;
    exp_gnt.push_back(1'b1);
    exp_mem.push_back('{1'b0, 32'h300, 4'hF, 32'd0});
    @(posedge clk); #1;
    ls_req = 1'b1; ls_we = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h300;
    wait_gnt(1'b1);
    @(posedge clk); #1 ls_req = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_zero("mid_reset");
    hold_rv = 1'b0;
    stray_req++;
    repeat (4) @(negedge clk);
    if_op(32'h100, 32'h0000_0013, 3);
    ls_op(1'b0, 3'b100, 32'h200, 32'd0, 4'b0001, 32'd0, 1'b0, 32'h0000_0033, 3);

    // Both requesters held: four LS grants, then IF is forced in; slow memory grant
    gnt_delay = 3;
    for (int i = 0; i < 4; i++) begin
      exp_gnt.push_back(1'b1);
      exp_mem.push_back('{1'b0, 32'h400 + 32'(4 * i), 4'hF, 32'd0});
      exp_resp.push_back('{1'b1, ~(32'h400 + 32'(4 * i)), 1'b0, 0});
    end
    exp_gnt.push_back(1'b0);
    exp_mem.push_back('{1'b0, 32'h500, 4'hF, 32'd0});
    exp_resp.push_back('{1'b0, ~32'h500, 1'b0, 0});
    exp_gnt.push_back(1'b1);
    exp_mem.push_back('{1'b0, 32'h410, 4'hF, 32'd0});
    exp_resp.push_back('{1'b1, ~32'h410, 1'b0, 0});
    exp_gnt.push_back(1'b0);
    exp_mem.push_back('{1'b0, 32'h504, 4'hF, 32'd0});
    exp_resp.push_back('{1'b0, ~32'h504, 1'b0, 0});
    target = resp_seen + 7;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          @(posedge clk); #1;
          ls_req = 1'b1; ls_we = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h400 + 32'(4 * i);
          wait_gnt(1'b1);
        end
        @(posedge clk); #1 ls_req = 1'b0;
      end
      begin
        for (int i = 0; i < 2; i++) begin
          @(posedge clk); #1;
          if_req = 1'b1; if_addr = 32'h500 + 32'(4 * i);
          wait_gnt(1'b0);
        end
        @(posedge clk); #1 if_req = 1'b0;
      end
    join
    wait_done(target);
    gnt_delay = 0;

    repeat (3) @(negedge clk);
    chk("exp_gnt_left", exp_gnt.size(), 0);
    chk("exp_mem_left", exp_mem.size(), 0);
    chk("exp_resp_left", exp_resp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
